// File: rtl/data_mem_storer_pkg.sv
// Shared definitions for the data-memory store path: select encodings, FSM states, lane offsets.
// The select encodings are common with the load path.
package dmem_pkg;

  localparam logic [2:0] SelByte = 3'b000;
  localparam logic [2:0] SelHalf = 3'b001;
  localparam logic [2:0] SelWord = 3'b010;

  localparam int unsigned NumLanes = 4;

  // MSB-first lanes: byte offset 0 is bits [31:24], halfword offset 2 is bits [15:0].
  localparam logic [NumLanes-1:0] ByteLaneMsb = 4'b1000;
  localparam logic [1:0]          HalfHiOff   = 2'd0;
  localparam logic [1:0]          HalfLoOff   = 2'd2;
  localparam logic [NumLanes-1:0] HalfHiBe    = 4'b1100;
  localparam logic [NumLanes-1:0] HalfLoBe    = 4'b0011;
  localparam logic [NumLanes-1:0] WordBe      = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMerge,
    StWr,
    StErr
  } state_e;

endpackage

// File: rtl/data_mem_storer_if.sv
// Request/completion and memory-port bundle for data_mem_storer.
// Optional mem_byte_en is present only when DMEM_BYTE_MASK_EN is defined.
interface data_mem_storer_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_select;
  logic        done;
  logic        err;

  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  mem_byte_en;
`endif

  modport req_slv (
    input  req_valid, req_addr, req_wdata, req_select,
    output req_ready, done, err
  );

  modport req_mst (
    output req_valid, req_addr, req_wdata, req_select,
    input  req_ready, done, err
  );

  modport mem_mst (
`ifdef DMEM_BYTE_MASK_EN
    output mem_byte_en,
`endif
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport mem_slv (
`ifdef DMEM_BYTE_MASK_EN
    input  mem_byte_en,
`endif
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_merge.sv
// Combinational lane placement: inserts right-aligned store data into the addressed lane(s).
// byte_en_o is all-zero for an illegal select or a misaligned offset, which doubles as legality.
module data_mem_merge
  import dmem_pkg::*;
(
  input  logic [31:0]         old_i,
  input  logic [31:0]         wdata_i,
  input  logic [2:0]          sel_i,
  input  logic [1:0]          off_i,
  output logic [31:0]         merged_o,
  output logic [NumLanes-1:0] byte_en_o
);

  logic [31:0] rep;
  logic [31:0] mask;

  always_comb begin
    byte_en_o = '0;
    rep       = '0;
    case (sel_i)
      SelByte: begin
        byte_en_o = ByteLaneMsb >> off_i;
        rep       = {4{wdata_i[7:0]}};
      end
      SelHalf: begin
        if (off_i == HalfHiOff) byte_en_o = HalfHiBe;
        if (off_i == HalfLoOff) byte_en_o = HalfLoBe;
        rep = {2{wdata_i[15:0]}};
      end
      SelWord: begin
        if (off_i == 2'd0) byte_en_o = WordBe;
        rep = wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    mask     = {{8{byte_en_o[3]}}, {8{byte_en_o[2]}}, {8{byte_en_o[1]}}, {8{byte_en_o[0]}}};
    merged_o = (old_i & ~mask) | (rep & mask);
  end

endmodule

// File: rtl/data_mem_storer.sv
// Store unit: byte/halfword/word stores via read-modify-write, or direct masked writes
// when DMEM_BYTE_MASK_EN is defined.
module data_mem_storer
  import dmem_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  data_mem_storer_if.req_slv  req,
  data_mem_storer_if.mem_mst  mem
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
`ifdef DMEM_BYTE_MASK_EN
  logic [NumLanes-1:0] be_q, be_d;
`endif

  logic [31:0]         m_old, m_wdata, m_merged;
  logic [2:0]          m_sel;
  logic [1:0]          m_off;
  logic [NumLanes-1:0] m_be;
  logic                accept;

  // In IDLE the merger looks at the incoming request (legality and masked placement);
  // otherwise it works on the latched request against the word just read.
  always_comb begin
    if (state_q == StIdle) begin
      m_old   = '0;
      m_wdata = req.req_wdata;
      m_sel   = req.req_select;
      m_off   = req.req_addr[1:0];
    end else begin
      m_old   = mem.mem_rdata;
      m_wdata = wdata_q;
      m_sel   = sel_q;
      m_off   = addr_q[1:0];
    end
  end

  data_mem_merge u_merge (
    .old_i     (m_old),
    .wdata_i   (m_wdata),
    .sel_i     (m_sel),
    .off_i     (m_off),
    .merged_o  (m_merged),
    .byte_en_o (m_be)
  );

  assign accept = req.req_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    data_d  = data_q;
`ifdef DMEM_BYTE_MASK_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          sel_d   = req.req_select;
          if (m_be == '0) begin
            state_d = StErr;
          end else begin
`ifdef DMEM_BYTE_MASK_EN
            data_d  = m_merged;
            be_d    = m_be;
            state_d = StWr;
`else
            data_d  = req.req_wdata;
            state_d = (req.req_select == SelWord) ? StWr : StRd;
`endif
          end
        end
      end
      StRd:    state_d = StMerge;
      StMerge: begin
        data_d  = m_merged;
        state_d = StWr;
      end
      StWr:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
`ifdef DMEM_BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
`ifdef DMEM_BYTE_MASK_EN
      be_q    <= be_d;
`endif
    end
  end

  always_comb begin
    req.req_ready = (state_q == StIdle);
    req.done      = 1'b0;
    req.err       = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_rd_en = 1'b0;
    mem.mem_wr_en = 1'b0;
    mem.mem_wdata = '0;
`ifdef DMEM_BYTE_MASK_EN
    mem.mem_byte_en = '0;
`endif
    unique case (state_q)
      StRd: begin
        mem.mem_rd_en = 1'b1;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
      end
      StMerge: mem.mem_addr = {addr_q[31:2], 2'b00};
      StWr: begin
        mem.mem_wr_en = 1'b1;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_wdata = data_q;
        req.done      = 1'b1;
`ifdef DMEM_BYTE_MASK_EN
        mem.mem_byte_en = be_q;
`endif
      end
      StErr: begin
        req.done = 1'b1;
        req.err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_storer.sv
// Directed self-checking bench for data_mem_storer: word/sub-word stores, illegal requests,
// reset abort and back-to-back hold; byte-mask store when DMEM_BYTE_MASK_EN is defined.
module tb_data_mem_storer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   rd_cnt;
  int   wr300_cnt;
  logic [31:0] mem_word;

  data_mem_storer_if u_if ();

  data_mem_storer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (u_if),
    .mem     (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: read data appears the cycle after mem_rd_en, garbage otherwise.
  always @(posedge clk) begin
    u_if.mem_rdata <= u_if.mem_rd_en ? mem_word : 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (u_if.mem_rd_en && u_if.mem_wr_en) begin
        errors++;
        $display("FAIL strobe_exclusive: rd_en=%b wr_en=%b, required not both high",
                 u_if.mem_rd_en, u_if.mem_wr_en);
      end
      if (u_if.mem_wr_en) wr_cnt++;
      if (u_if.mem_rd_en) rd_cnt++;
      if (u_if.mem_wr_en && u_if.mem_addr == 32'h300) wr300_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    u_if.req_addr   = a;
    u_if.req_wdata  = d;
    u_if.req_select = s;
    u_if.req_valid  = 1'b1;
    checks++;
    if (u_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%b required 1", u_if.req_ready);
    end
    step();
    u_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({u_if.req_ready, u_if.done, u_if.err, u_if.mem_rd_en, u_if.mem_wr_en} !== 5'b10000 ||
        u_if.mem_addr !== 32'h0 || u_if.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/done/err/rd/wr=%b addr=%h wdata=%h required 10000 0 0",
               {u_if.req_ready, u_if.done, u_if.err, u_if.mem_rd_en, u_if.mem_wr_en},
               u_if.mem_addr, u_if.mem_wdata);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_word();
    int rd0;
    rd0 = rd_cnt;
    issue(32'h100, 32'hDEAD_BEEF, 3'b010);
    checks++;
    if (u_if.mem_wr_en !== 1'b1 || u_if.mem_addr !== 32'h100 ||
        u_if.mem_wdata !== 32'hDEAD_BEEF || u_if.done !== 1'b1 || u_if.err !== 1'b0) begin
      errors++;
      $display("FAIL word_store: wr=%b addr=%h wdata=%h done=%b err=%b required 1 100 deadbeef 1 0",
               u_if.mem_wr_en, u_if.mem_addr, u_if.mem_wdata, u_if.done, u_if.err);
    end
    step();
    checks++;
    if (u_if.done !== 1'b0 || u_if.req_ready !== 1'b1 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL word_after: done=%b ready=%b reads=%0d required 0 1 0",
               u_if.done, u_if.req_ready, rd_cnt - rd0);
    end
  endtask

  task automatic test_subword(input string name, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] s, input logic [31:0] old,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    mem_word = old;
    issue(a, d, s);
    checks++;
    if (u_if.mem_rd_en !== 1'b1 || u_if.mem_addr !== exp_addr || u_if.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_rd: rd=%b addr=%h done=%b required 1 %h 0",
               name, u_if.mem_rd_en, u_if.mem_addr, exp_addr, u_if.done);
    end
    step();
    checks++;
    if (u_if.mem_rd_en !== 1'b0 || u_if.mem_wr_en !== 1'b0 || u_if.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_merge: rd=%b wr=%b done=%b required 0 0 0",
               name, u_if.mem_rd_en, u_if.mem_wr_en, u_if.done);
    end
    step();
    checks++;
    if (u_if.mem_wr_en !== 1'b1 || u_if.mem_addr !== exp_addr ||
        u_if.mem_wdata !== exp_wdata || u_if.done !== 1'b1 || u_if.err !== 1'b0) begin
      errors++;
      $display("FAIL %s_wr: wr=%b addr=%h wdata=%h done=%b err=%b required 1 %h %h 1 0",
               name, u_if.mem_wr_en, u_if.mem_addr, u_if.mem_wdata, u_if.done, u_if.err,
               exp_addr, exp_wdata);
    end
    step();
  endtask

  task automatic test_illegal(input string name, input logic [31:0] a, input logic [2:0] s);
    issue(a, 32'h1234_5678, s);
    checks++;
    if (u_if.done !== 1'b1 || u_if.err !== 1'b1 || u_if.mem_rd_en !== 1'b0 ||
        u_if.mem_wr_en !== 1'b0 || u_if.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL %s: done=%b err=%b rd=%b wr=%b addr=%h required 1 1 0 0 0",
               name, u_if.done, u_if.err, u_if.mem_rd_en, u_if.mem_wr_en, u_if.mem_addr);
    end
    step();
    checks++;
    if (u_if.done !== 1'b0 || u_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after: done=%b ready=%b required 0 1", name, u_if.done, u_if.req_ready);
    end
  endtask

  task automatic test_reset_abort();
    int wr0;
    wr0 = wr_cnt;
    mem_word = 32'h1122_3344;
    issue(32'h102, 32'h0000_00AB, 3'b000);
    step();
    reset_n = 1'b0;
    step();
    checks++;
    if ({u_if.req_ready, u_if.done, u_if.err, u_if.mem_rd_en, u_if.mem_wr_en} !== 5'b10000 ||
        u_if.mem_addr !== 32'h0 || u_if.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: rdy/done/err/rd/wr=%b addr=%h wdata=%h required 10000 0 0",
               {u_if.req_ready, u_if.done, u_if.err, u_if.mem_rd_en, u_if.mem_wr_en},
               u_if.mem_addr, u_if.mem_wdata);
    end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (wr_cnt != wr0 || u_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_write: writes=%0d ready=%b required 0 1", wr_cnt - wr0,
               u_if.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit accepted;
    int w0;
    w0 = wr300_cnt;
    accepted = 1'b0;
    issue(32'h200, 32'hAAAA_5555, 3'b010);
    u_if.req_addr   = 32'h300;
    u_if.req_wdata  = 32'h1234_5678;
    u_if.req_select = 3'b010;
    u_if.req_valid  = 1'b1;
    checks++;
    if (u_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: req_ready=%b required 0", u_if.req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (u_if.req_ready === 1'b1) begin
        step();
        u_if.req_valid = 1'b0;
        accepted = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL b2b_accept: accepted=0 required 1 within 10 cycles");
    end
    checks++;
    if (u_if.mem_wdata !== 32'h1234_5678 || u_if.mem_addr !== 32'h300 || u_if.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write: wdata=%h addr=%h done=%b required 12345678 300 1",
               u_if.mem_wdata, u_if.mem_addr, u_if.done);
    end
    repeat (4) step();
    checks++;
    if (wr300_cnt - w0 != 1) begin
      errors++;
      $display("FAIL b2b_once: writes=%0d required 1", wr300_cnt - w0);
    end
  endtask

`ifdef DMEM_BYTE_MASK_EN
  task automatic test_byte_mask();
    int rd0;
    rd0 = rd_cnt;
    issue(32'h103, 32'h0000_0055, 3'b000);
    checks++;
    if (u_if.mem_wr_en !== 1'b1 || u_if.mem_byte_en !== 4'b0001 ||
        u_if.mem_wdata[7:0] !== 8'h55 || u_if.done !== 1'b1 || u_if.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL byte_mask: wr=%b be=%b wdata=%h done=%b addr=%h required 1 0001 xx55 1 100",
               u_if.mem_wr_en, u_if.mem_byte_en, u_if.mem_wdata, u_if.done, u_if.mem_addr);
    end
    step();
    checks++;
    if (rd_cnt != rd0) begin
      errors++;
      $display("FAIL byte_mask_noread: reads=%0d required 0", rd_cnt - rd0);
    end
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    wr_cnt          = 0;
    rd_cnt          = 0;
    wr300_cnt       = 0;
    mem_word        = 32'h0;
    reset_n         = 1'b0;
    u_if.req_valid  = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_wdata  = '0;
    u_if.req_select = '0;

    test_reset();
    test_word();
`ifdef DMEM_BYTE_MASK_EN
    test_byte_mask();
`else
    test_subword("byte", 32'h102, 32'h0000_00AB, 3'b000, 32'h1122_3344, 32'h100, 32'h1122_AB44);
    test_subword("half", 32'h106, 32'h0000_CAFE, 3'b001, 32'h1122_3344, 32'h104, 32'h1122_CAFE);
    test_subword("byte0", 32'h200, 32'hFFFF_FF9C, 3'b000, 32'h0102_0304, 32'h200, 32'h9C02_0304);
`endif
    test_illegal("half_misaligned", 32'h101, 3'b001);
    test_illegal("select_011", 32'h100, 3'b011);
    test_illegal("word_misaligned", 32'h102, 3'b010);
`ifndef DMEM_BYTE_MASK_EN
    test_reset_abort();
`endif
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_storer.md
DATA_MEM_STORER -- requirements
Module: data_mem_storer

Interface
REQ-001 Port clk  in  1  -- single clock; all state updates on rising edge.
REQ-002 Port reset_n  in  1  -- reset is synchronous and active-low.
REQ-003 Port req_valid  in  1  -- store request present.
REQ-004 Port req_ready  out  1  -- block can accept a request; high only in IDLE.
REQ-005 Port req_addr  in  32  -- byte address of the store.
REQ-006 Port req_wdata  in  32  -- store data, right-aligned: byte in [7:0], halfword in [15:0].
REQ-007 Port req_select  in  3  -- width code: 000 byte, 001 halfword, 010 word; all other codes are illegal for stores.
REQ-008 Port done  out  1  -- one-cycle completion pulse.
REQ-009 Port err  out  1  -- qualified by done; request rejected, no memory write issued.
REQ-010 Port mem_addr  out  32  -- word-aligned address, req_addr with bits [1:0] forced to 00.
REQ-011 Port mem_rd_en  out  1  -- word read strobe; mem_rdata is valid the following cycle.
REQ-012 Port mem_rdata  in  32  -- read word.
REQ-013 Port mem_wr_en / mem_wdata  out  1 / 32  -- word write strobe and write data.

Function
REQ-014 Lane mapping is MSB-first and matches the load path: byte offset k occupies mem word bits [31-8k : 24-8k]; halfword offset 0 occupies [31:16] and offset 2 occupies [15:0].
REQ-015 A request is accepted on the cycle where req_valid and req_ready are both high; addr, wdata and select are latched on that cycle.
REQ-016 FSM states: IDLE, RD, MERGE, WR, ERR.
REQ-017 IDLE transitions on accept: to ERR for an illegal select or misalignment (halfword with addr[0]=1, word with addr[1:0]!=0); otherwise to WR for a word store and to RD for a sub-word store.
REQ-018 RD: mem_rd_en=1 for exactly one cycle, then go to MERGE.
REQ-019 MERGE: capture mem_rdata and replace only the addressed lane(s) with the store data; every other bit is preserved bit-exact. Then go to WR.
REQ-020 WR: mem_wr_en=1, done=1, err=0 for one cycle, then go to IDLE.
REQ-021 ERR: done=1, err=1 for one cycle with no mem_rd_en or mem_wr_en, then go to IDLE.
REQ-022 Latency from the accept edge to done: word 1 cycle, sub-word 3 cycles, error 1 cycle.
REQ-023 mem_addr holds the latched aligned address in RD and WR; it is 0 in IDLE and ERR.
REQ-024 A request presented while busy is not accepted; the requester holds it until req_ready=1.
REQ-025 At most one mem_rd_en or mem_wr_en is asserted per cycle; both are never high together.

Reset
REQ-026 While reset_n=0 at a clock edge: state goes to IDLE; req_ready=1; done, err, mem_rd_en and mem_wr_en go to 0; mem_addr, mem_wdata and the latched request go to 0.
REQ-027 Reset has priority over every transition. A reset sampled in RD, MERGE or WR aborts the operation, and no mem_wr_en is issued for it.

Configuration
REQ-028 Macro DMEM_BYTE_MASK_EN. When defined: an output mem_byte_en (4 bits, bit 3 = bits [31:24]) is added; all legal stores go IDLE to WR with the lane placed per REQ-014 and only the addressed lanes enabled; RD and MERGE are unused and mem_rd_en stays 0.
REQ-029 When DMEM_BYTE_MASK_EN is undefined: the port is absent and stores use the read-modify-write flow of REQ-017 to REQ-020.

Structure
REQ-030 Package dmem_pkg holds the select encodings (shared with the load path), the FSM state enum and the lane-offset constants.
REQ-031 Sub-module data_mem_merge is purely combinational: old word, store data, select and offset in; merged word and byte-enable out. It is the only place lane logic lives.

Verification
REQ-032 Word store, addr 0x100, data 0xDEADBEEF: 1 cycle after accept, mem_wr_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never asserted.
REQ-033 Byte store, addr 0x102, data 0x000000AB, mem_rdata 0x11223344: mem_rd_en at +1, mem_wdata=0x1122AB44 at +3 with done=1.
REQ-034 Halfword store, addr 0x106, data 0x0000CAFE, mem_rdata 0x11223344: mem_addr=0x104, mem_wdata=0x1122CAFE.
REQ-035 Illegal cases: halfword at addr 0x101, then select=011: each gives done=1 and err=1 one cycle after accept, with no memory strobes.
REQ-036 Reset pulse in MERGE during a byte store: no mem_wr_en; next cycle req_ready=1 and all outputs 0. A back-to-back request held during busy is accepted exactly once.
REQ-037 With DMEM_BYTE_MASK_EN defined, byte store at addr 0x103 with data 0x55: mem_byte_en=0001, mem_wdata[7:0]=0x55, done at +1, no read.
